spi_multi_periph_bridge: RTL

- SPI-slave-to-register bridge, successor to the single-peripheral SPI register harness.
- Parametrised in address width, data width and peripheral count; adds burst auto-increment and a read strobe.
- Sits between the SPI pins (chip top) and up to N_PERIPH peripheral register ports.
- Runs entirely in the system clock domain; SPI inputs are oversampled through synchronizers.

---
 rtl/spi_bridge_pkg.sv | 9 +
 rtl/spi_edge_detect.sv | 18 +
 rtl/spi_sync.sv | 19 +
 rtl/spi_multi_periph_bridge.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the multi-peripheral SPI register bridge.
package spi_bridge_pkg;
   typedef enum logic [1:0] {IDLE, CMD, ADDR, DATA} state_t;

   localparam int CMD_W_BIT   = 7;
   localparam int CMD_INC_BIT = 6;
   localparam int CMD_IDX_MSB = 5;
   localparam int STATUS_IDX  = 63;
endpackage

// File: rtl/spi_edge_detect.sv
// Turns the synchronized SPI clock into single-clk rise/fall pulses.
module spi_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic sclk_s,
   output logic rise,
   output logic fall
);
   logic sclk_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sclk_d <= 1'b0;
      else        sclk_d <= sclk_s;
   end

   assign rise = sclk_s & ~sclk_d;
   assign fall = ~sclk_s & sclk_d;
endmodule

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for a single asynchronous input; reset value is selectable.
module spi_sync #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] sync_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_reg <= {STAGES{RESET_VAL}};
      else        sync_reg <= (sync_reg << 1) | STAGES'(d);
   end

   assign q = sync_reg[STAGES-1];
endmodule

// File: rtl/spi_multi_periph_bridge.sv
// SPI mode-0 slave to N-peripheral register bridge with burst auto-increment and read strobe.
// Optional status block at index 63 is built when SPI_BRIDGE_STATUS_EN is defined.
module spi_multi_periph_bridge
   import spi_bridge_pkg::*;
#(
   parameter int ADDR_W      = 4,
   parameter int DATA_W      = 8,
   parameter int N_PERIPH    = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       spi_cs_n,
   input  logic                       spi_clk,
   input  logic                       spi_mosi,
   output logic                       spi_miso,
   output logic [N_PERIPH-1:0]        reg_sel,
   output logic [ADDR_W-1:0]          reg_addr,
   output logic [DATA_W-1:0]          reg_wdata,
   output logic                       reg_wr,
   output logic                       reg_rd,
   input  logic [N_PERIPH*DATA_W-1:0] reg_rdata
);
   localparam int CNT_W = $clog2(DATA_W);

   logic                cs_n_s, sclk_s, mosi_s, sclk_rise, sclk_fall;
   state_t              state_reg, state_next;
   logic [CNT_W-1:0]    bit_cnt_reg;
   logic [DATA_W-1:0]   shift_reg, shift_next, tx_reg, rd_word, periph_rdata;
   logic                w_reg, inc_reg, tx_hold_reg, done_reg;
   logic [5:0]          idx_reg;
   logic [ADDR_W-1:0]   reg_addr_reg;
   logic [N_PERIPH-1:0] reg_sel_reg, sel_dec;
   logic [DATA_W-1:0]   reg_wdata_reg;
   logic                reg_wr_reg, reg_rd_reg;
   logic                last_bit, in_range, active_rise, cmd_done, addr_done, word_done;

   spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst_n(rst_n), .d(spi_cs_n), .q(cs_n_s));
   spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(spi_clk),  .q(sclk_s));
   spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(spi_mosi), .q(mosi_s));

   spi_edge_detect u_edge (.clk(clk), .rst_n(rst_n), .sclk_s(sclk_s), .rise(sclk_rise), .fall(sclk_fall));

   assign shift_next  = {shift_reg[DATA_W-2:0], mosi_s};
   assign in_range    = int'(idx_reg) < N_PERIPH;
   assign active_rise = sclk_rise & ~cs_n_s & (state_reg != IDLE);
   assign cmd_done    = active_rise & last_bit & (state_reg == CMD);
   assign addr_done   = active_rise & last_bit & (state_reg == ADDR);
   assign word_done   = active_rise & last_bit & (state_reg == DATA);

   always_comb begin
      if (state_reg == DATA) last_bit = (bit_cnt_reg == CNT_W'(DATA_W-1));
      else                   last_bit = (bit_cnt_reg == CNT_W'(7));
   end

   always_comb begin
      sel_dec      = '0;
      periph_rdata = '0;
      for (int i = 0; i < N_PERIPH; i++) begin
         if (idx_reg == 6'(i)) begin
            sel_dec[i]   = 1'b1;
            periph_rdata = reg_rdata[i*DATA_W +: DATA_W];
         end
      end
   end

`ifdef SPI_BRIDGE_STATUS_EN
   logic              short_reg, bad_reg, stat_sel;
   logic [7:0]        wcnt_reg;
   logic [DATA_W-1:0] stat_rdata;

   assign stat_sel = (idx_reg == 6'(STATUS_IDX));

   always_comb begin
      stat_rdata = '0;
      if (reg_addr_reg == ADDR_W'(0))      stat_rdata[7:0] = {6'b0, bad_reg, short_reg};
      else if (reg_addr_reg == ADDR_W'(1)) stat_rdata[7:0] = wcnt_reg;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         short_reg <= 1'b0;
         bad_reg   <= 1'b0;
         wcnt_reg  <= 8'd0;
      end else begin
         if (reg_wr_reg) wcnt_reg <= wcnt_reg + 8'd1;
         if (reg_wr_reg && stat_sel && reg_addr_reg == ADDR_W'(0)) begin
            short_reg <= 1'b0;
            bad_reg   <= 1'b0;
         end else begin
            // A frame ending with bits already shifted into the current field is short.
            if (cs_n_s && state_reg != IDLE && bit_cnt_reg != '0) short_reg <= 1'b1;
            if (addr_done && !in_range && !stat_sel)               bad_reg   <= 1'b1;
         end
      end
   end
`endif

   always_comb begin
      rd_word = '0;
      if (in_range) rd_word = periph_rdata;
`ifdef SPI_BRIDGE_STATUS_EN
      else if (stat_sel) rd_word = stat_rdata;
`endif
   end

   always_comb begin
      state_next = state_reg;
      if (cs_n_s) state_next = IDLE;
      else begin
         case (state_reg)
            IDLE:    state_next = CMD;
            CMD:     if (cmd_done)  state_next = ADDR;
            ADDR:    if (addr_done) state_next = DATA;
            default: state_next = state_reg;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_reg   <= '0;
         shift_reg     <= '0;
         tx_reg        <= '0;
         tx_hold_reg   <= 1'b0;
         done_reg      <= 1'b0;
         w_reg         <= 1'b0;
         inc_reg       <= 1'b0;
         idx_reg       <= '0;
         reg_addr_reg  <= '0;
         reg_sel_reg   <= '0;
         reg_wdata_reg <= '0;
         reg_wr_reg    <= 1'b0;
         reg_rd_reg    <= 1'b0;
      end else begin
         reg_wr_reg <= 1'b0;
         reg_rd_reg <= 1'b0;
         done_reg   <= 1'b0;
         if (cs_n_s) bit_cnt_reg <= '0;
         else if (active_rise) begin
            shift_reg   <= shift_next;
            bit_cnt_reg <= last_bit ? '0 : bit_cnt_reg + 1'b1;
         end
         if (cmd_done) begin
            w_reg   <= shift_next[CMD_W_BIT];
            inc_reg <= shift_next[CMD_INC_BIT];
            idx_reg <= shift_next[CMD_IDX_MSB:0];
         end
         if (addr_done) begin
            reg_addr_reg <= shift_next[ADDR_W-1:0];
            reg_sel_reg  <= in_range ? sel_dec : '0;
            reg_rd_reg   <= ~w_reg;
         end
         if (word_done) begin
            done_reg <= 1'b1;
            if (w_reg) begin
               reg_wdata_reg <= shift_next;
               reg_wr_reg    <= 1'b1;
            end
         end
         // Increment lands after the write strobe; the next read fetch sees the new address.
         if (done_reg) begin
            if (inc_reg) reg_addr_reg <= reg_addr_reg + 1'b1;
            reg_rd_reg <= ~w_reg & ~cs_n_s & (state_reg == DATA);
         end
         if (sclk_fall && state_reg == DATA && !w_reg) begin
            if (tx_hold_reg) tx_hold_reg <= 1'b0;
            else             tx_reg      <= tx_reg << 1;
         end
         if (reg_rd_reg) begin
            tx_reg      <= rd_word;
            tx_hold_reg <= 1'b1;
         end
      end
   end

   assign spi_miso  = (state_reg == DATA && !w_reg) ? tx_reg[DATA_W-1] : 1'b0;
   assign reg_sel   = reg_sel_reg;
   assign reg_addr  = reg_addr_reg;
   assign reg_wdata = reg_wdata_reg;
   assign reg_wr    = reg_wr_reg;
   assign reg_rd    = reg_rd_reg;
endmodule
